// File: rtl/md5_crack_dispatcher_if.sv
// -----------------------------------------------------------------------------
// md5_crack_dispatcher_if
// Bundle between the candidate dispatcher and the replicated md5 cores.
//   core_enable  [NUM_CORES]     dispatcher -> cores, lane running
//   core_pattern [64*NUM_CORES]  dispatcher -> cores, lane i in [64i+63:64i],
//                                ASCII, most significant character first
//   core_valid   [NUM_CORES]     cores -> dispatcher, candidate finished (strobe)
//   core_hit     [NUM_CORES]     cores -> dispatcher, hash matched (with valid)
// master = dispatcher side, slave = core side.
// -----------------------------------------------------------------------------
interface md5_crack_dispatcher_if #(
    parameter int NUM_CORES = 4
);
    logic [NUM_CORES-1:0]    core_enable;
    logic [64*NUM_CORES-1:0] core_pattern;
    logic [NUM_CORES-1:0]    core_valid;
    logic [NUM_CORES-1:0]    core_hit;

    modport master (
        output core_enable,
        output core_pattern,
        input  core_valid,
        input  core_hit
    );

    modport slave (
        input  core_enable,
        input  core_pattern,
        output core_valid,
        output core_hit
    );
endinterface

// File: rtl/md5_crack_dispatcher.sv
// -----------------------------------------------------------------------------
// md5_crack_dispatcher
// Enumerates 8-digit ASCII decimal passwords across NUM_CORES md5 lanes, lane i
// testing i, i+N, i+2N, ... and collects the first match or reports exhaustion.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   start      one-cycle pulse, accepted only when idle / found / exhausted
//   core_bus   md5_crack_dispatcher_if.master (enable/pattern out, valid/hit in)
//   busy       search in progress (load and run phases)
//   found      a match was latched into answer
//   exhausted  every candidate tested without a match
//   answer     matching ASCII password, zero until found
//   tested     candidates completed in the current search (saturating)
// -----------------------------------------------------------------------------
module md5_crack_dispatcher #(
    parameter int          NUM_CORES = 4,
    parameter logic [31:0] MAX_BCD   = 32'h99999999,
    parameter int          CNT_W     = 28
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    md5_crack_dispatcher_if.master core_bus,
    output logic                   busy,
    output logic                   found,
    output logic                   exhausted,
    output logic [63:0]            answer,
    output logic [CNT_W-1:0]       tested
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_FOUND   = 3'd3;
    localparam logic [2:0] S_EXHAUST = 3'd4;

    localparam logic [3:0] STRIDE = 4'(NUM_CORES);

    logic [2:0]           state_r;
    logic [31:0]          lane_bcd_r  [NUM_CORES];
    logic [63:0]          pattern_r   [NUM_CORES];
    logic [NUM_CORES-1:0] enable_r;

    logic [32:0]          lane_sum_s  [NUM_CORES];
    logic [NUM_CORES-1:0] lane_retire_s;
    logic [NUM_CORES-1:0] hit_vec_s;
    logic [NUM_CORES-1:0] miss_vec_s;
    logic                 hit_any_s;
    logic [63:0]          hit_pattern_s;
    logic [CNT_W:0]       tested_sum_s;

    // Ripple-carry BCD add of a single-digit increment; bit 32 is the carry
    // out of the most significant digit.
    function automatic logic [32:0] bcd_add(input logic [31:0] v, input logic [3:0] inc);
        logic [4:0]  d;
        logic [3:0]  c;
        logic [31:0] s;
        c = inc;
        s = 32'h0;
        for (int k = 0; k < 8; k++) begin
            d = {1'b0, v[4*k +: 4]} + {1'b0, c};
            if (d > 5'd9) begin
                s[4*k +: 4] = d[3:0] - 4'd10;
                c = 4'd1;
            end else begin
                s[4*k +: 4] = d[3:0];
                c = 4'd0;
            end
        end
        return {c[0], s};
    endfunction

    // Each BCD digit becomes its ASCII character '0'..'9'.
    function automatic logic [63:0] bcd_to_ascii(input logic [31:0] v);
        logic [63:0] p;
        for (int k = 0; k < 8; k++) begin
            p[8*k +: 8] = {4'h3, v[4*k +: 4]};
        end
        return p;
    endfunction

    function automatic logic [3:0] popcount(input logic [NUM_CORES-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int k = 0; k < NUM_CORES; k++) begin
            c = c + {3'b000, v[k]};
        end
        return c;
    endfunction

    // Next candidate per lane and whether advancing would run past the range.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            lane_sum_s[i]    = bcd_add(lane_bcd_r[i], STRIDE);
            lane_retire_s[i] = lane_sum_s[i][32] | (lane_sum_s[i][31:0] > MAX_BCD);
        end
    end

    // Hit/miss qualification, lowest-index hit selection and tested update.
    always_comb begin
        hit_vec_s     = core_bus.core_valid & core_bus.core_hit & enable_r;
        miss_vec_s    = core_bus.core_valid & ~core_bus.core_hit & enable_r;
        hit_any_s     = |hit_vec_s;
        hit_pattern_s = 64'h0;
        // Walk downward so the lowest hitting lane is the last one written.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            hit_pattern_s = hit_vec_s[i] ? pattern_r[i] : hit_pattern_s;
        end
        tested_sum_s = {1'b0, tested} + (CNT_W+1)'(popcount(core_bus.core_valid & enable_r));
    end

    // Drive the core bus from the lane registers.
    always_comb begin
        core_bus.core_pattern = {(64*NUM_CORES){1'b0}};
        for (int i = 0; i < NUM_CORES; i++) begin
            core_bus.core_pattern[64*i +: 64] = pattern_r[i];
        end
        core_bus.core_enable = enable_r;
    end

    // Search control FSM, lane registers and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            enable_r  <= {NUM_CORES{1'b0}};
            busy      <= 1'b0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            answer    <= 64'h0;
            tested    <= {CNT_W{1'b0}};
            for (int i = 0; i < NUM_CORES; i++) begin
                lane_bcd_r[i] <= 32'h0;
                pattern_r[i]  <= 64'h0;
            end
        end else begin
            case (state_r)
                S_IDLE, S_FOUND, S_EXHAUST: begin
                    if (start) begin
                        found     <= 1'b0;
                        exhausted <= 1'b0;
                        answer    <= 64'h0;
                        tested    <= {CNT_W{1'b0}};
                        busy      <= 1'b1;
                        state_r   <= S_LOAD;
                        // Lane i starts at i; i < 10 so its BCD encoding is i.
                        for (int i = 0; i < NUM_CORES; i++) begin
                            lane_bcd_r[i] <= 32'(i);
                            pattern_r[i]  <= bcd_to_ascii(32'(i));
                            enable_r[i]   <= (32'(i) <= MAX_BCD);
                        end
                    end
                end
                S_LOAD: begin
                    state_r <= S_RUN;
                end
                S_RUN: begin
                    tested <= tested_sum_s[CNT_W] ? {CNT_W{1'b1}} : tested_sum_s[CNT_W-1:0];
                    if (hit_any_s) begin
                        answer   <= hit_pattern_s;
                        found    <= 1'b1;
                        busy     <= 1'b0;
                        enable_r <= {NUM_CORES{1'b0}};
                        state_r  <= S_FOUND;
                    end else if (enable_r == {NUM_CORES{1'b0}}) begin
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= S_EXHAUST;
                    end else begin
                        for (int i = 0; i < NUM_CORES; i++) begin
                            if (miss_vec_s[i]) begin
                                if (lane_retire_s[i]) begin
                                    enable_r[i] <= 1'b0;
                                end else begin
                                    lane_bcd_r[i] <= lane_sum_s[i][31:0];
                                    pattern_r[i]  <= bcd_to_ascii(lane_sum_s[i][31:0]);
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    busy     <= 1'b0;
                    enable_r <= {NUM_CORES{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md5_crack_dispatcher.sv
module tb_md5_crack_dispatcher;

    localparam int          NA       = 4;
    localparam logic [31:0] MAXA     = 32'h00000109;
    localparam int          MAXA_DEC = 109;
    localparam int          NC       = 3;
    localparam logic [31:0] MAXC     = 32'h00000001;
    localparam int          MAXC_DEC = 1;
    localparam int          TIMEOUT  = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_c;
    logic        busy_a, found_a, exhausted_a;
    logic [63:0] answer_a;
    logic [27:0] tested_a;
    logic        busy_c, found_c, exhausted_c;
    logic [63:0] answer_c;
    logic [27:0] tested_c;
    logic [63:0] tgt0_a, tgt1_a;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    md5_crack_dispatcher_if #(.NUM_CORES(NA)) bus_a ();
    md5_crack_dispatcher_if #(.NUM_CORES(NC)) bus_c ();

    md5_crack_dispatcher #(.NUM_CORES(NA), .MAX_BCD(MAXA), .CNT_W(28)) dut_a (
        .clk(clk), .reset(rst), .start(start_a), .core_bus(bus_a),
        .busy(busy_a), .found(found_a), .exhausted(exhausted_a),
        .answer(answer_a), .tested(tested_a)
    );

    md5_crack_dispatcher #(.NUM_CORES(NC), .MAX_BCD(MAXC), .CNT_W(28)) dut_c (
        .clk(clk), .reset(rst), .start(start_c), .core_bus(bus_c),
        .busy(busy_c), .found(found_c), .exhausted(exhausted_c),
        .answer(answer_c), .tested(tested_c)
    );

    // Mock cores: valid strobes after the lane pattern has been stable for a
    // few cycles; hit when the pattern equals one of the targets.
    logic [63:0]   last_a [NA];
    logic [NA-1:0] seen_a;
    int            tmr_a  [NA];
    always @(posedge clk) begin
        for (int i = 0; i < NA; i++) begin
            if (!bus_a.core_enable[i]) begin
                seen_a[i] <= 1'b0;
                tmr_a[i]  <= 0;
                bus_a.core_valid[i] <= 1'b0;
                bus_a.core_hit[i]   <= 1'b0;
            end else if (!seen_a[i] || bus_a.core_pattern[64*i +: 64] != last_a[i]) begin
                seen_a[i] <= 1'b1;
                last_a[i] <= bus_a.core_pattern[64*i +: 64];
                tmr_a[i]  <= 1;
                bus_a.core_valid[i] <= 1'b0;
                bus_a.core_hit[i]   <= 1'b0;
            end else begin
                tmr_a[i] <= tmr_a[i] + 1;
                bus_a.core_valid[i] <= (tmr_a[i] == 4);
                bus_a.core_hit[i]   <= (tmr_a[i] == 4) &&
                    (bus_a.core_pattern[64*i +: 64] == tgt0_a || bus_a.core_pattern[64*i +: 64] == tgt1_a);
            end
        end
    end

    logic [63:0]   last_c [NC];
    logic [NC-1:0] seen_c;
    int            tmr_c  [NC];
    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            bus_c.core_hit[i] <= 1'b0;
            if (!bus_c.core_enable[i]) begin
                seen_c[i] <= 1'b0;
                tmr_c[i]  <= 0;
                bus_c.core_valid[i] <= 1'b0;
            end else if (!seen_c[i] || bus_c.core_pattern[64*i +: 64] != last_c[i]) begin
                seen_c[i] <= 1'b1;
                last_c[i] <= bus_c.core_pattern[64*i +: 64];
                tmr_c[i]  <= 1;
                bus_c.core_valid[i] <= 1'b0;
            end else begin
                tmr_c[i] <= tmr_c[i] + 1;
                bus_c.core_valid[i] <= (tmr_c[i] == 4);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Decimal value to 8-character ASCII string, MSB character first.
    function automatic logic [63:0] ascii(input int v);
        logic [63:0] r;
        int x;
        x = v;
        for (int k = 0; k < 8; k++) begin
            r[8*k +: 8] = 8'h30 + 8'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: lanes run in lockstep rounds; round r tests r*n .. r*n+n-1
    // (values above maxd skipped). The first round containing a target ends
    // the search, the lowest value in it wins, and every in-range value of
    // the rounds up to and including that one is counted.
    task automatic model(input int n, input int maxd, input int t0, input int t1,
                         output logic e_found, output logic [63:0] e_ans, output int e_tested);
        e_found  = 1'b0;
        e_ans    = 64'h0;
        e_tested = 0;
        for (int r = 0; (r * n <= maxd) && !e_found; r++) begin
            for (int i = 0; i < n; i++) begin
                if (r * n + i <= maxd) begin
                    e_tested++;
                    if (!e_found && (r * n + i == t0 || r * n + i == t1)) begin
                        e_found = 1'b1;
                        e_ans   = ascii(r * n + i);
                    end
                end
            end
        end
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_busy"},      64'(busy_a), 64'd0);
        chk({tag, "_found"},     64'(found_a), 64'd0);
        chk({tag, "_exhausted"}, 64'(exhausted_a), 64'd0);
        chk({tag, "_answer"},    answer_a, 64'd0);
        chk({tag, "_tested"},    64'(tested_a), 64'd0);
        chk({tag, "_enable"},    64'(bus_a.core_enable), 64'd0);
        chk({tag, "_pat0"},      bus_a.core_pattern[63:0], 64'd0);
        chk({tag, "_pat3"},      bus_a.core_pattern[255:192], 64'd0);
    endtask

    task automatic pulse_start_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        for (int k = 0; k < TIMEOUT && !(found_a || exhausted_a); k++) @(negedge clk);
        chk({tag, "_done"}, 64'(found_a | exhausted_a), 64'd1);
    endtask

    // One full search on dut_a; t < 0 means no such target.
    task automatic run_a(input string tag, input int t0, input int t1);
        logic        e_found;
        logic [63:0] e_ans;
        int          e_tested;
        tgt0_a = (t0 < 0) ? 64'h0 : ascii(t0);
        tgt1_a = (t1 < 0) ? 64'h0 : ascii(t1);
        pulse_start_a();
        chk({tag, "_load_busy"},   64'(busy_a), 64'd1);
        chk({tag, "_load_enable"}, 64'(bus_a.core_enable), 64'hF);
        chk({tag, "_load_tested"}, 64'(tested_a), 64'd0);
        for (int i = 0; i < NA; i++) begin
            chk($sformatf("%s_load_pat%0d", tag, i), bus_a.core_pattern[64*i +: 64], ascii(i));
        end
        wait_done_a(tag);
        model(NA, MAXA_DEC, t0, t1, e_found, e_ans, e_tested);
        chk({tag, "_found"},     64'(found_a), 64'(e_found));
        chk({tag, "_exhausted"}, 64'(exhausted_a), 64'(!e_found));
        chk({tag, "_answer"},    answer_a, e_ans);
        chk({tag, "_tested"},    64'(tested_a), 64'(e_tested));
        chk({tag, "_enable"},    64'(bus_a.core_enable), 64'd0);
        chk({tag, "_busy"},      64'(busy_a), 64'd0);
    endtask

    initial begin
        logic        e_found;
        logic [63:0] e_ans;
        int          e_tested;
        int          r0, r1;

        rst     = 1'b1;
        start_a = 1'b0;
        start_c = 1'b0;
        tgt0_a  = 64'h0;
        tgt1_a  = 64'h0;
        repeat (3) @(negedge clk);
        chk_reset_a("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed searches: early hit, BCD carry, dual same-cycle hit, no hit.
        run_a("hit6", 6, -1);
        run_a("carry100", 100, -1);
        run_a("dual5_7", 7, 5);
        run_a("exhaust", -1, -1);

        // Randomized targets, some beyond the range so the search exhausts.
        for (int k = 0; k < 6; k++) begin
            r0 = int'($urandom_range(0, 115));
            r1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 115)) : -1;
            run_a($sformatf("rand%0d", k), r0, r1);
        end

        // start while running is ignored.
        tgt0_a = ascii(6);
        tgt1_a = 64'h0;
        pulse_start_a();
        for (int k = 0; k < TIMEOUT && tested_a == 28'd0; k++) @(negedge clk);
        chk("busy_start_round1", 64'(tested_a), 64'd4);
        pulse_start_a();
        chk("busy_start_tested", 64'(tested_a), 64'd4);
        chk("busy_start_busy",   64'(busy_a), 64'd1);
        chk("busy_start_pat0",   bus_a.core_pattern[63:0], ascii(4));
        wait_done_a("busy_start");
        model(NA, MAXA_DEC, 6, -1, e_found, e_ans, e_tested);
        chk("busy_start_answer", answer_a, e_ans);
        chk("busy_start_final",  64'(tested_a), 64'(e_tested));

        // Asynchronous reset in the middle of a search.
        tgt0_a = 64'h0;
        pulse_start_a();
        repeat (12) @(negedge clk);
        chk("midrst_busy_before", 64'(busy_a), 64'd1);
        #2 rst = 1'b1;
        #1 chk_reset_a("midrst");
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        run_a("after_rst", 3, -1);

        // Three lanes with only two candidates in range.
        @(negedge clk) start_c = 1'b1;
        @(negedge clk) start_c = 1'b0;
        chk("c_load_enable", 64'(bus_c.core_enable), 64'h3);
        chk("c_load_pat1",   bus_c.core_pattern[127:64], ascii(1));
        for (int k = 0; k < TIMEOUT && !(found_c || exhausted_c); k++) @(negedge clk);
        model(NC, MAXC_DEC, -1, -1, e_found, e_ans, e_tested);
        chk("c_exhausted", 64'(exhausted_c), 64'(!e_found));
        chk("c_found",     64'(found_c), 64'(e_found));
        chk("c_tested",    64'(tested_c), 64'(e_tested));
        chk("c_answer",    answer_c, e_ans);
        chk("c_busy",      64'(busy_c), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
